// File: rtl/mem_port_arbiter_if.sv
// Fetch/data requester ports plus the shared memory command port of mem_port_arbiter.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_wdata;
   logic [3:0]        dm_wstrb;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [31:0]       dm_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   logic              err;

   modport master (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      input  mem_ack, mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output err
   );

   modport slave (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
      output mem_ack, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port, one transaction in flight, with timeout.
// Grant registered 1 cycle after req; response 1 cycle after mem_ack. ARB_ROUND_ROBIN_EN selects round robin.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   mem_port_arbiter_if.master bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

   state_t            state;
   logic [7:0]        wait_cnt;
   logic              owner;        // 1 = data port; also the last requester served
   logic              pick_dm;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic [31:0]       sel_wdata;
   logic [3:0]        sel_wstrb;

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      pick_dm = bus.dm_req;
      if (bus.dm_req && bus.if_req)
         pick_dm = ~owner;
   end
`else
   always_comb pick_dm = bus.dm_req;
`endif

   // Fetch commands are always reads with no write payload.
   always_comb begin
      sel_addr  = pick_dm ? bus.dm_addr : bus.if_addr;
      sel_we    = pick_dm & bus.dm_we;
      sel_wdata = pick_dm ? bus.dm_wdata : 32'h0;
      sel_wstrb = pick_dm ? bus.dm_wstrb : 4'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         wait_cnt      <= 8'h0;
         owner         <= 1'b0;
         bus.if_gnt    <= 1'b0;
         bus.if_rvalid <= 1'b0;
         bus.if_rdata  <= 32'h0;
         bus.dm_gnt    <= 1'b0;
         bus.dm_rvalid <= 1'b0;
         bus.dm_rdata  <= 32'h0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0;
         bus.mem_wstrb <= 4'h0;
         bus.err       <= 1'b0;
      end else begin
         bus.if_gnt    <= 1'b0;
         bus.dm_gnt    <= 1'b0;
         bus.if_rvalid <= 1'b0;
         bus.dm_rvalid <= 1'b0;
         bus.err       <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.if_req || bus.dm_req) begin
                  owner         <= pick_dm;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= sel_we;
                  bus.mem_addr  <= sel_addr;
                  bus.mem_wdata <= sel_wdata;
                  bus.mem_wstrb <= sel_wstrb;
                  bus.if_gnt    <= ~pick_dm;
                  bus.dm_gnt    <= pick_dm;
                  wait_cnt      <= 8'h0;
                  state         <= BUSY;
               end
            end
            BUSY: begin
               // Ack is checked first so an ack on the last allowed cycle still completes cleanly.
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  wait_cnt    <= 8'h0;
                  state       <= IDLE;
                  if (owner) begin
                     bus.dm_rvalid <= 1'b1;
                     bus.dm_rdata  <= bus.mem_we ? 32'h0 : bus.mem_rdata;
                  end else begin
                     bus.if_rvalid <= 1'b1;
                     bus.if_rdata  <= bus.mem_rdata;
                  end
               end else if (wait_cnt + 8'd1 == MAX_CNT) begin
                  bus.mem_req <= 1'b0;
                  bus.err     <= 1'b1;
                  wait_cnt    <= 8'h0;
                  state       <= IDLE;
                  if (owner) begin
                     bus.dm_rvalid <= 1'b1;
                     bus.dm_rdata  <= 32'h0;
                  end else begin
                     bus.if_rvalid <= 1'b1;
                     bus.if_rdata  <= 32'h0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
